g4_other_chain_walker: RTL

//  Controller directly upstream of the G4 "protocol other" search-table stage.
//  - Accepts one packet tuple plus a chain head index per lookup.
//  - Drives the table stage's search_index/tupleData and follows next_index hop by hop.
//  - Stops on the first match, a null pointer or the hop limit, then returns ruleID downstream.
//  - Also serialises rule-table writes (we/din) into the same table port.

---
 rtl/g4_search_pkg.sv | 21 ++
 rtl/g4_other_chain_walker.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/g4_search_pkg.sv
// Shared definitions for the G4 "protocol other" search path: index/tuple/entry
// widths shared with the table stage, the null chain pointer and the walker
// state encoding.
`timescale 1ns/1ps
package g4_search_pkg;

  localparam int unsigned INDEX_BIT_LEN    = 11;
  localparam int unsigned PACKET_BIT_LEN   = 104;
  localparam int unsigned ENTRY_DATA_WIDTH = 171;

  // All-ones index terminates a chain
  localparam logic [INDEX_BIT_LEN-1:0] NULL_INDEX = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } walk_state_e;

endpackage

// File: rtl/g4_other_chain_walker.sv
// Chain walker in front of the G4 "protocol other" search table.
// Accepts a tuple + chain head, reads table entries hop by hop (1-cycle table
// latency, 2 cycles per hop) until a match, a null next pointer or MAX_HOPS,
// then presents the result until out_ready. Rule-table writes share the table
// port and are only accepted while idle, ahead of any pending lookup.
// Ports:
//   clk, rst                 clock, async active-high reset
//   in_*                     lookup request (valid/ready, tuple, head index)
//   upd_*                    table write request (valid/ready, index, data)
//   tbl_*                    table stage port (search_index, tupleData, we, din;
//                            match, ruleID, next_index returned one cycle later)
//   out_*                    result (valid/ready, match, ruleID, hops, overflow)
`timescale 1ns/1ps
module g4_other_chain_walker
  import g4_search_pkg::*;
#(
  parameter int unsigned MAX_HOPS = 16,
  parameter int unsigned HOP_W    = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [PACKET_BIT_LEN-1:0]   in_tuple,
  input  logic [INDEX_BIT_LEN-1:0]    in_head_index,
  input  logic                        upd_valid,
  output logic                        upd_ready,
  input  logic [INDEX_BIT_LEN-1:0]    upd_index,
  input  logic [ENTRY_DATA_WIDTH-1:0] upd_data,
  output logic [INDEX_BIT_LEN-1:0]    tbl_search_index,
  output logic [PACKET_BIT_LEN-1:0]   tbl_tupleData,
  output logic                        tbl_we,
  output logic [ENTRY_DATA_WIDTH-1:0] tbl_din,
  input  logic                        tbl_match,
  input  logic [INDEX_BIT_LEN-1:0]    tbl_ruleID,
  input  logic [INDEX_BIT_LEN-1:0]    tbl_next_index,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_match,
  output logic [INDEX_BIT_LEN-1:0]    out_ruleID,
  output logic [HOP_W-1:0]            out_hops,
  output logic                        out_overflow
);

  walk_state_e                state_q;
  logic [INDEX_BIT_LEN-1:0]   cur_q;
  logic [PACKET_BIT_LEN-1:0]  tuple_q;
  logic [HOP_W-1:0]           hops_q;
  logic                       idle_c;

  // Gated by rst so a write strobe can never leak out while reset is held
  assign idle_c    = (state_q == ST_IDLE) && !rst;
  assign upd_ready = idle_c && upd_valid;
  assign in_ready  = idle_c && !upd_valid;
  assign tbl_we    = upd_ready;

  // Table port is shared: write address while writing, else the current hop
  assign tbl_search_index = tbl_we ? upd_index : cur_q;
  assign tbl_din          = upd_data;
  assign tbl_tupleData    = tuple_q;

  // Walk FSM, hop counter and result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cur_q        <= '0;
      tuple_q      <= '0;
      hops_q       <= '0;
      out_valid    <= 1'b0;
      out_match    <= 1'b0;
      out_ruleID   <= '0;
      out_hops     <= '0;
      out_overflow <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            tuple_q <= in_tuple;
            cur_q   <= in_head_index;
            hops_q  <= '0;
            if (in_head_index == NULL_INDEX) begin
              // Empty chain: report a miss without touching the table
              out_valid    <= 1'b1;
              out_match    <= 1'b0;
              out_ruleID   <= '0;
              out_hops     <= '0;
              out_overflow <= 1'b0;
              state_q      <= ST_DONE;
            end else begin
              state_q <= ST_ISSUE;
            end
          end
        end

        ST_ISSUE: begin
          hops_q  <= hops_q + HOP_W'(1);
          state_q <= ST_WAIT;
        end

        ST_WAIT: begin
          // Table result for the hop issued last cycle; match beats null beats limit
          if (tbl_match) begin
            out_valid    <= 1'b1;
            out_match    <= 1'b1;
            out_ruleID   <= tbl_ruleID;
            out_hops     <= hops_q;
            out_overflow <= 1'b0;
            state_q      <= ST_DONE;
          end else if (tbl_next_index == NULL_INDEX) begin
            out_valid    <= 1'b1;
            out_match    <= 1'b0;
            out_ruleID   <= '0;
            out_hops     <= hops_q;
            out_overflow <= 1'b0;
            state_q      <= ST_DONE;
          end else if (hops_q == HOP_W'(MAX_HOPS)) begin
            out_valid    <= 1'b1;
            out_match    <= 1'b0;
            out_ruleID   <= '0;
            out_hops     <= hops_q;
            out_overflow <= 1'b1;
            state_q      <= ST_DONE;
          end else begin
            cur_q   <= tbl_next_index;
            state_q <= ST_ISSUE;
          end
        end

        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
